// File: rtl/seg7_scan_if.sv
// Display bus between the register block (master) and the scan driver (slave).
// The bus is level-based with no valid/ready: the master holds the display
// fields steady as plain levels, and the driver samples all of them together
// once per frame on its snapshot. Changes between snapshots are not seen until
// the next frame. seg/an/frame flow back to the board pins and the master.
interface seg7_scan_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] di;
  logic [DIGITS-1:0]   dp;
  logic [8*DIGITS-1:0] pixels;
  logic                direct;
  logic                blank_lz;
  logic [DIGITS-1:0]   blink;
  logic [3:0]          bright;
  logic                en;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame;

  modport master (
    output di, dp, pixels, direct, blank_lz, blink, bright, en,
    input  seg, an, frame
  );

  modport slave (
    input  di, dp, pixels, direct, blank_lz, blink, bright, en,
    output seg, an, frame
  );
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment driver. Scans DIGITS digits, one slot of
// 2^PRE clocks each, from a per-frame snapshot of the display inputs, with PWM
// brightness, leading-zero blanking, decimal points and per-digit blink.
// seg/an are active-low and registered one clock after the scan state.
module seg7_scan #(
  parameter int DIGITS       = 8,
  parameter int PRE          = 10,
  parameter int BLINK_FRAMES = 64
) (
  input logic        clk,
  input logic        resetn,
  seg7_scan_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  // Segment pattern {G,F,E,D,C,B,A}, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h58;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  logic [PRE-1:0]      pre_cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       fcnt;
  logic                phase;
  logic                first;
  logic                tick;
  logic                snap;

  logic [4*DIGITS-1:0] s_di;
  logic [DIGITS-1:0]   s_dp;
  logic [8*DIGITS-1:0] s_pixels;
  logic                s_direct;
  logic                s_blank_lz;
  logic [DIGITS-1:0]   s_blink;
  logic [3:0]          s_bright;
  logic                s_en;

  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic [7:0]          cur_pix;
  logic                cur_lz;
  logic                cur_blink;
  logic                lit;
  logic [7:0]          seg_d;
  logic [DIGITS-1:0]   an_d;

  assign tick = &pre_cnt;
  assign snap = (tick && (idx == IDX_LAST)) || first;

  // Slot and digit counters; the release cycle holds pre_cnt at 0 so the
  // first slot after reset is full length and aligned with the first snapshot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_cnt <= '0;
      idx     <= '0;
      first   <= 1'b1;
    end else begin
      first   <= 1'b0;
      pre_cnt <= first ? '0 : pre_cnt + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Frame snapshot of all display inputs plus the blink frame counter/phase.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_di       <= '0;
      s_dp       <= '0;
      s_pixels   <= '0;
      s_direct   <= 1'b0;
      s_blank_lz <= 1'b0;
      s_blink    <= '0;
      s_bright   <= '0;
      s_en       <= 1'b0;
      fcnt       <= '0;
      phase      <= 1'b0;
    end else if (snap) begin
      s_di       <= bus.di;
      s_dp       <= bus.dp;
      s_pixels   <= bus.pixels;
      s_direct   <= bus.direct;
      s_blank_lz <= bus.blank_lz;
      s_blink    <= bus.blink;
      s_bright   <= bus.bright;
      s_en       <= bus.en;
      if (fcnt == FCNT_LAST) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (s_di[4*i +: 4] == 4'h0);
      lz_mask[i] = s_blank_lz && !s_direct && zero_run;
    end
  end

  // Select the current digit's fields and form the next seg/an values.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_pix   = '0;
    cur_lz    = 1'b0;
    cur_blink = 1'b0;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = s_di[4*i +: 4];
        cur_dp    = s_dp[i];
        cur_pix   = s_pixels[8*(DIGITS-1-i) +: 8];
        cur_lz    = lz_mask[i];
        cur_blink = s_blink[i];
        an_d[i]   = 1'b0;
      end
    end
    lit   = s_en && (pre_cnt[PRE-1 -: 4] <= s_bright) && !cur_lz && !(phase && cur_blink);
    seg_d = s_direct ? ~cur_pix : ~{cur_dp, hex7(cur_nib)};
  end

  // Registered pin outputs and frame pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.an    <= '1;
      bus.seg   <= 8'hFF;
      bus.frame <= 1'b0;
    end else begin
      bus.frame <= snap;
      if (lit) begin
        bus.an  <= an_d;
        bus.seg <= seg_d;
      end else begin
        bus.an  <= '1;
        bus.seg <= 8'hFF;
      end
    end
  end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Parametrised multiplexed 7-segment display driver. It time-multiplexes `DIGITS` common-anode digits from a single clock and supports three things the fixed 8-digit driver lacked: a synchronous active-low reset, frame-consistent input snapshots, and per-frame features (PWM brightness, leading-zero blanking, decimal points, per-digit blink). It sits between the memory-mapped display register block and the board `seg`/`an` pins, and replaces the fixed 8-digit driver.

## Interface
Parameters:
- `DIGITS`, 8: number of digits, 1..16.
- `PRE`, 10: slot-counter width; each digit slot is 2^PRE clocks. `PRE` must be ≥ 4.
- `BLINK_FRAMES`, 64: number of frames per blink half-period, ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `di`  in  4*DIGITS  hex nibbles; digit i is `di[4i+3:4i]`.
- `dp`  in  DIGITS  decimal point per digit; 1 = lit.
- `pixels`  in  8*DIGITS  raw segments for direct mode. Digit i uses `pixels[8(DIGITS-1-i)+7 : 8(DIGITS-1-i)]` (MSB byte = digit 0). Bit order is {dp,G,F,E,D,C,B,A}.
- `direct`  in  1  1 = raw pixel mode; 0 = hex decode.
- `blank_lz`  in  1  blank leading zeros (hex mode only).
- `blink`  in  DIGITS  per-digit blink enable.
- `bright`  in  4  brightness; duty = (bright+1)/16.
- `en`  in  1  display enable; 0 = all anodes off.
- `seg`  out  8  {dp,G,F,E,D,C,B,A}, active-low, registered.
- `an`  out  DIGITS  anodes, active-low, registered.
- `frame`  out  1  one-cycle pulse on each snapshot.

## Operation
- `pre_cnt` (PRE bits) increments every clock and wraps. `tick` = (`pre_cnt` == all ones).
- `idx`, the digit index, advances on `tick` and wraps from DIGITS-1 to 0.
- **Snapshot (`snap`).** Asserted on (`tick` && `idx`==DIGITS-1), or on the first clock after reset release (`first` flag, set during reset).
  - On `snap`, these inputs are registered: `di`, `dp`, `pixels`, `direct`, `blank_lz`, `blink`, `bright`, `en`.
  - The blanking mask is computed from the same snapshot.
  - Inputs are ignored between snapshots, so one frame never mixes two values.
- **Leading-zero mask.** Digit i is blanked iff `blank_lz`=1, `direct`=0, i>0, and nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. An inner zero is shown.
- **Hex decode.** Segments use A=bit0 … G=bit6:
  - 0:ABCDEF, 1:BC, 2:ABDEG, 3:ABCDG, 4:BCFG, 5:ACDFG, 6:ACDEFG, 7:ABC
  - 8:all, 9:ABCDFG, A:ABCEFG, b:CDEFG, C:DEG, d:BCDEG, E:ADEFG, F:AEFG
  - `seg[7]` = ~`dp[idx]`.
- **Direct mode.** `seg` = ~(pixel byte of `idx`). The dp comes from the pixel byte; the `dp` input is ignored.
- **Blink.** `fcnt` counts snaps from 0 to BLINK_FRAMES-1. On the snap where `fcnt` wraps, `phase` toggles. When `phase`=1, every digit with `blink[i]`=1 is dark: anode off.
- **Lit condition.** The anode for `idx` is active when all of the following hold: `en`, `pre_cnt[PRE-1:PRE-4]` ≤ `bright`, not LZ-blanked, and not blink-dark.
  - When the digit is not lit: `an` = all ones and `seg` = 8'hFF.
  - At most one anode bit is low in any cycle.
- **Reset.** Reset values while `resetn`=0 at a clock edge:
  - `pre_cnt`=0, `idx`=0, `fcnt`=0, `phase`=0, snapshot registers=0, `first`=1.
  - Outputs: `an`=all ones, `seg`=8'hFF, `frame`=0.
  - Reset mid-frame aborts the scan; nothing from the old frame persists.

## Timing
- `seg` and `an` have 1 clock of latency from (`idx`, `pre_cnt`, snapshot).
- Outputs change on the clock after the state changes.
- `frame` is registered. It is high in the cycle after each snap edge.
- The first snap is at the first edge with `resetn`=1; the first lit output appears one edge later.
- Slot length is exactly 2^PRE clocks. Frame length is DIGITS·2^PRE clocks.
- An input change is displayed from the first slot after the next snap: worst case frame + 2^PRE + 1 clocks.
- The `bright` duty segment is aligned to the start of the slot. With `bright`=15 the digit is on for the whole slot.
- DIGITS=1: `idx` stays 0, and a snap occurs every `tick`.

## Test plan
Common bench settings: DIGITS=8, PRE=4, BLINK_FRAMES=2, `en`=1, `bright`=15.

1. **Reset mid-frame.** Hold `resetn`=0 for 3 clocks mid-frame, then release.
   - Required: `an`=8'hFF and `seg`=8'hFF during reset.
   - `frame` pulses once, 1 clock after release.
   - digit 0 is lit 2 clocks after release and stays lit for 16 clocks.
2. **Hex decode and leading-zero blanking.** `di`=32'h00000A05, `blank_lz`=1, `dp`=8'h02.
   - Digit 0: `seg`=8'h92.
   - Digit 1: `seg`=8'h40 (inner zero shown, dp lit).
   - Digit 2: `seg`=8'h88.
   - Digits 3–7: `an` stays 8'hFF for their whole slot.
3. **Direct mode.** `direct`=1, `pixels`=64'h0102_0408_1020_4080.
   - Digit 0: `seg`=8'hFE.
   - Digit 7: `seg`=8'h7F.
   - The `dp` and `blank_lz` inputs have no effect.
4. **Brightness.** `bright`=3.
   - Each digit's anode is low for exactly 4 of the 16 clocks in its slot (`pre_cnt` 0..3).
   - `bright`=15 gives 16 of 16.
5. **Snapshot atomicity.** Change `di` from 32'h11111111 to 32'h22222222 while `idx`=3.
   - Digits 3–7 still show "1".
   - "2" appears on all digits only after the next `frame` pulse.
6. **Blink.** `blink`=8'h01.
   - Digit 0 is dark for 2 frames, lit for 2 frames, and the pattern repeats.
   - Digits 1–7 are unaffected.
